// File: rtl/kmeans_prod_accum.sv
// -----------------------------------------------------------------------------
// kmeans_prod_accum
//
// Purpose:
//   Streaming accumulator placed directly after the 7x10 unsigned multiplier of
//   the k-means datapath. It sums unsigned products arriving on a valid/ready
//   stream until a beat marked last, then emits one registered record per group
//   (sum, member count, overflow flag) to the centroid-update stage.
//
// Build option:
//   KMEANS_ACC_SATURATE_EN  defined   : sum and count clamp at their maximum.
//                           undefined : sum and count wrap modulo 2^width.
//   In both builds out_ovf flags any wrap/clamp that happened in the group.
//
// Ports:
//   ap_clk       in   1      clock, rising edge
//   ap_rst_n     in   1      asynchronous active-low reset
//   in_tdata     in   IN_W   unsigned product
//   in_tvalid    in   1      product valid
//   in_tready    out  1      accumulator can accept a beat
//   in_tlast     in   1      beat closes the current group
//   out_tdata    out  ACC_W  group sum
//   out_count    out  CNT_W  beats in the group, including the last beat
//   out_ovf      out  1      sum or count overflowed during this group
//   out_tvalid   out  1      result record valid
//   out_tready   in   1      consumer accepts the record
// -----------------------------------------------------------------------------
module kmeans_prod_accum #(
   parameter int IN_W  = 17,
   parameter int ACC_W = 32,
   parameter int CNT_W = 16
) (
   input  logic             ap_clk,
   input  logic             ap_rst_n,
   input  logic [IN_W-1:0]  in_tdata,
   input  logic             in_tvalid,
   output logic             in_tready,
   input  logic             in_tlast,
   output logic [ACC_W-1:0] out_tdata,
   output logic [CNT_W-1:0] out_count,
   output logic             out_ovf,
   output logic             out_tvalid,
   input  logic             out_tready
);

   // Reduce a one-bit-wider sum to ACC_W bits: clamp or wrap on carry-out.
   function automatic logic [ACC_W-1:0] acc_limit(input logic [ACC_W:0] s);
`ifdef KMEANS_ACC_SATURATE_EN
      return s[ACC_W] ? {ACC_W{1'b1}} : s[ACC_W-1:0];
`else
      return s[ACC_W-1:0];
`endif
   endfunction

   // Same treatment for the member count.
   function automatic logic [CNT_W-1:0] cnt_limit(input logic [CNT_W:0] c);
`ifdef KMEANS_ACC_SATURATE_EN
      return c[CNT_W] ? {CNT_W{1'b1}} : c[CNT_W-1:0];
`else
      return c[CNT_W-1:0];
`endif
   endfunction

   logic [ACC_W-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ovf_q, ovf_d;
   logic [ACC_W-1:0] out_data_q, out_data_d;
   logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
   logic             out_ovf_q, out_ovf_d;
   logic             out_vld_q, out_vld_d;

   logic             accept;
   logic [ACC_W:0]   sum_full;
   logic [CNT_W:0]   cnt_full;
   logic             beat_ovf;

   // A held record blocks input only while the consumer is stalling; when the
   // consumer takes it this cycle a new last beat may overwrite it in place.
   assign in_tready = !out_vld_q || out_tready;
   assign accept    = in_tvalid && in_tready;

   // One extra bit on each adder exposes the carry that signals overflow.
   assign sum_full = {1'b0, acc_q} + {{(ACC_W + 1 - IN_W){1'b0}}, in_tdata};
   assign cnt_full = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
   assign beat_ovf = sum_full[ACC_W] | cnt_full[CNT_W];

   always_comb begin
      acc_d      = acc_q;
      cnt_d      = cnt_q;
      ovf_d      = ovf_q;
      out_data_d = out_data_q;
      out_cnt_d  = out_cnt_q;
      out_ovf_d  = out_ovf_q;
      out_vld_d  = out_vld_q;

      // Record handed off and nothing new to replace it.
      if (out_vld_q && out_tready)
         out_vld_d = 1'b0;

      if (accept) begin
         if (in_tlast) begin
            out_data_d = acc_limit(sum_full);
            out_cnt_d  = cnt_limit(cnt_full);
            out_ovf_d  = ovf_q | beat_ovf;
            out_vld_d  = 1'b1;
            acc_d      = '0;
            cnt_d      = '0;
            ovf_d      = 1'b0;
         end else begin
            acc_d = acc_limit(sum_full);
            cnt_d = cnt_limit(cnt_full);
            ovf_d = ovf_q | beat_ovf;
         end
      end
   end

   // Single register stage: accumulator state and output record.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         acc_q      <= '0;
         cnt_q      <= '0;
         ovf_q      <= 1'b0;
         out_data_q <= '0;
         out_cnt_q  <= '0;
         out_ovf_q  <= 1'b0;
         out_vld_q  <= 1'b0;
      end else begin
         acc_q      <= acc_d;
         cnt_q      <= cnt_d;
         ovf_q      <= ovf_d;
         out_data_q <= out_data_d;
         out_cnt_q  <= out_cnt_d;
         out_ovf_q  <= out_ovf_d;
         out_vld_q  <= out_vld_d;
      end
   end

   assign out_tdata  = out_data_q;
   assign out_count  = out_cnt_q;
   assign out_ovf    = out_ovf_q;
   assign out_tvalid = out_vld_q;

endmodule

// File: tb/tb_kmeans_prod_accum.sv
// -----------------------------------------------------------------------------
// tb_kmeans_prod_accum
//
// Directed bench for kmeans_prod_accum. Two instances share clock and reset:
//   u_dut : default widths (IN_W=17, ACC_W=32, CNT_W=16)
//   u_sml : narrow widths (ACC_W=17, CNT_W=2) so sum and count overflow
//           are reachable with a handful of beats.
// Expected values follow KMEANS_ACC_SATURATE_EN when that macro is defined.
// -----------------------------------------------------------------------------
module tb_kmeans_prod_accum;

   logic        clk;
   logic        rst_n;

   logic [16:0] in_tdata;
   logic        in_tvalid;
   logic        in_tready;
   logic        in_tlast;
   logic [31:0] out_tdata;
   logic [15:0] out_count;
   logic        out_ovf;
   logic        out_tvalid;
   logic        out_tready;

   logic [16:0] s_in_tdata;
   logic        s_in_tvalid;
   logic        s_in_tready;
   logic        s_in_tlast;
   logic [16:0] s_out_tdata;
   logic [1:0]  s_out_count;
   logic        s_out_ovf;
   logic        s_out_tvalid;
   logic        s_out_tready;

   int checks;
   int errors;

   kmeans_prod_accum #(.IN_W(17), .ACC_W(32), .CNT_W(16)) u_dut (
      .ap_clk     (clk),
      .ap_rst_n   (rst_n),
      .in_tdata   (in_tdata),
      .in_tvalid  (in_tvalid),
      .in_tready  (in_tready),
      .in_tlast   (in_tlast),
      .out_tdata  (out_tdata),
      .out_count  (out_count),
      .out_ovf    (out_ovf),
      .out_tvalid (out_tvalid),
      .out_tready (out_tready)
   );

   kmeans_prod_accum #(.IN_W(17), .ACC_W(17), .CNT_W(2)) u_sml (
      .ap_clk     (clk),
      .ap_rst_n   (rst_n),
      .in_tdata   (s_in_tdata),
      .in_tvalid  (s_in_tvalid),
      .in_tready  (s_in_tready),
      .in_tlast   (s_in_tlast),
      .out_tdata  (s_out_tdata),
      .out_count  (s_out_count),
      .out_ovf    (s_out_ovf),
      .out_tvalid (s_out_tvalid),
      .out_tready (s_out_tready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Advance one edge, then settle 1 time unit past it before sampling.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input logic [16:0] d, input logic last);
      in_tdata  = d;
      in_tlast  = last;
      in_tvalid = 1'b1;
      tick();
   endtask

   task automatic sbeat(input logic [16:0] d, input logic last);
      s_in_tdata  = d;
      s_in_tlast  = last;
      s_in_tvalid = 1'b1;
      tick();
   endtask

   task automatic rec(input string tag, input logic v, input logic [31:0] d,
                      input logic [15:0] c, input logic o);
      chk({tag, ".vld"},   out_tvalid, v);
      chk({tag, ".data"},  out_tdata,  d);
      chk({tag, ".count"}, out_count,  c);
      chk({tag, ".ovf"},   out_ovf,    o);
   endtask

   logic [16:0] exp_sml_sum;
   logic [1:0]  exp_sml_cnt;

   initial begin
      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      in_tdata = '0;  in_tvalid = 1'b0;  in_tlast = 1'b0;  out_tready = 1'b0;
      s_in_tdata = '0; s_in_tvalid = 1'b0; s_in_tlast = 1'b0; s_out_tready = 1'b0;

      // Reset state
      #12;
      rec("reset", 1'b0, 32'd0, 16'd0, 1'b0);
      chk("reset.in_tready", in_tready, 1'b1);
      rst_n = 1'b1;
      tick();

      // Basic group 10, 20, 30(last)
      out_tready = 1'b1;
      beat(17'd10, 1'b0);
      chk("basic.b0.vld", out_tvalid, 1'b0);
      beat(17'd20, 1'b0);
      chk("basic.b1.vld", out_tvalid, 1'b0);
      beat(17'd30, 1'b1);
      rec("basic", 1'b1, 32'd60, 16'd3, 1'b0);
      in_tvalid = 1'b0;
      tick();
      chk("basic.vld_drop", out_tvalid, 1'b0);

      // Back-pressure: 129921 + 129921(last), consumer stalls 5 cycles
      out_tready = 1'b0;
      beat(17'd129921, 1'b0);
      beat(17'd129921, 1'b1);
      rec("bp.first", 1'b1, 32'd259842, 16'd2, 1'b0);
      in_tdata = 17'd7; in_tlast = 1'b1; in_tvalid = 1'b1;
      #1;
      chk("bp.in_tready_low", in_tready, 1'b0);
      for (int i = 0; i < 4; i++) begin
         tick();
         rec("bp.hold", 1'b1, 32'd259842, 16'd2, 1'b0);
         chk("bp.hold.in_tready", in_tready, 1'b0);
      end
      out_tready = 1'b1;
      #1;
      chk("bp.in_tready_high", in_tready, 1'b1);
      tick();
      rec("bp.next", 1'b1, 32'd7, 16'd1, 1'b0);
      in_tvalid = 1'b0;
      tick();
      chk("bp.vld_drop", out_tvalid, 1'b0);

      // Full rate: single-beat groups 1..4 back to back
      out_tready = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         beat(17'(i), 1'b1);
         rec($sformatf("full.%0d", i), 1'b1, 32'(i), 16'd1, 1'b0);
      end
      in_tvalid = 1'b0;
      tick();
      chk("full.vld_drop", out_tvalid, 1'b0);

      // Sum overflow on the narrow instance: 131071 + 1(last)
`ifdef KMEANS_ACC_SATURATE_EN
      exp_sml_sum = 17'd131071;
`else
      exp_sml_sum = 17'd0;
`endif
      s_out_tready = 1'b1;
      sbeat(17'd131071, 1'b0);
      sbeat(17'd1, 1'b1);
      chk("sovf.vld",   s_out_tvalid, 1'b1);
      chk("sovf.data",  s_out_tdata,  exp_sml_sum);
      chk("sovf.count", s_out_count,  2'd2);
      chk("sovf.ovf",   s_out_ovf,    1'b1);

      // Count overflow on the narrow instance: five beats of 1, 2-bit count
`ifdef KMEANS_ACC_SATURATE_EN
      exp_sml_cnt = 2'd3;
`else
      exp_sml_cnt = 2'd1;
`endif
      for (int i = 0; i < 4; i++) sbeat(17'd1, 1'b0);
      sbeat(17'd1, 1'b1);
      chk("covf.data",  s_out_tdata, 17'd5);
      chk("covf.count", s_out_count, exp_sml_cnt);
      chk("covf.ovf",   s_out_ovf,   1'b1);

      // Overflow flag must not leak into the following group
      sbeat(17'd3, 1'b1);
      chk("clean.data",  s_out_tdata, 17'd3);
      chk("clean.count", s_out_count, 2'd1);
      chk("clean.ovf",   s_out_ovf,   1'b0);
      s_in_tvalid = 1'b0;

      // Reset mid-group: leave a nonzero record on the outputs first
      beat(17'd50, 1'b1);
      rec("pre_rst", 1'b1, 32'd50, 16'd1, 1'b0);
      beat(17'd5, 1'b0);
      beat(17'd6, 1'b0);
      in_tvalid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      rec("mid_rst", 1'b0, 32'd0, 16'd0, 1'b0);
      tick();
      rec("mid_rst.edge", 1'b0, 32'd0, 16'd0, 1'b0);
      #3;
      rst_n = 1'b1;
      tick();
      beat(17'd9, 1'b1);
      rec("post_rst", 1'b1, 32'd9, 16'd1, 1'b0);
      in_tvalid = 1'b0;
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
